vpu_exec_dispatch: RTL

Issue-side controller for the VPU execution datapath. It accepts one vector command from the instruction decoder and collects up to `SRC_CNT` source operands from the operand fetch stream. It then drives the execution unit's `start`/`op_func`/`delay`/operand interface, waits for the unit's `done`, and returns the captured result to the writeback stage over a valid/ready handshake. Exactly one command is in flight at a time.

---
 rtl/vpu_exec_dispatch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/vpu_exec_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : vpu_exec_dispatch
// Description : Issue-side controller for the VPU execution datapath: collects
//               command operands, pulses the exec unit and returns its result.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_exec_dispatch #(
    parameter int DWIDTH  = 256,
    parameter int SRC_CNT = 3,
    parameter int OPF_W   = 8,
    parameter int DELAY_W = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [OPF_W-1:0]               cmd_opf_i,
    input  logic [DELAY_W-1:0]             cmd_delay_i,
    input  logic [$clog2(SRC_CNT+1)-1:0]   cmd_src_cnt_i,
    input  logic                           opnd_valid_i,
    output logic                           opnd_ready_o,
    input  logic [DWIDTH-1:0]              opnd_data_i,
    output logic                           start_o,
    output logic [OPF_W-1:0]               op_func_o,
    output logic [DELAY_W-1:0]             delay_o,
    output logic [SRC_CNT*DWIDTH-1:0]      operand_o,
    output logic [SRC_CNT-1:0]             operand_valid_o,
    input  logic                           done_i,
    input  logic [DWIDTH-1:0]              dout_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [DWIDTH-1:0]              res_data_o,
    output logic                           res_err_o,
    output logic                           busy_o
);

    localparam int                 c_CNT_W   = $clog2(SRC_CNT + 1);
    localparam logic [c_CNT_W:0]   c_CNT_MAX = (c_CNT_W + 1)'(SRC_CNT);
    localparam logic [c_CNT_W-1:0] c_IDX_ONE = c_CNT_W'(1);
    // Watchdog value in the last WAIT cycle before it saturates at all-ones.
    localparam logic [DELAY_W:0]   c_WD_LAST = {{DELAY_W{1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                      r_state_q,    w_state_d;
    logic [OPF_W-1:0]            r_opf_q,      w_opf_d;
    logic [DELAY_W-1:0]          r_delay_q,    w_delay_d;
    logic [c_CNT_W-1:0]          r_cnt_q,      w_cnt_d;
    logic [c_CNT_W-1:0]          r_idx_q,      w_idx_d;
    logic [SRC_CNT*DWIDTH-1:0]   r_operand_q,  w_operand_d;
    logic [SRC_CNT-1:0]          r_opv_q,      w_opv_d;
    logic [DELAY_W:0]            r_wd_q,       w_wd_d;
    logic [DWIDTH-1:0]           r_res_data_q, w_res_data_d;
    logic                        r_res_err_q,  w_res_err_d;
    logic [c_CNT_W-1:0]          w_cnt_clamped;

    assign w_cnt_clamped = ({1'b0, cmd_src_cnt_i} > c_CNT_MAX) ? c_CNT_W'(SRC_CNT)
                                                               : cmd_src_cnt_i;

    always_comb begin
        w_state_d    = r_state_q;
        w_opf_d      = r_opf_q;
        w_delay_d    = r_delay_q;
        w_cnt_d      = r_cnt_q;
        w_idx_d      = r_idx_q;
        w_operand_d  = r_operand_q;
        w_opv_d      = r_opv_q;
        w_wd_d       = r_wd_q;
        w_res_data_d = r_res_data_q;
        w_res_err_d  = r_res_err_q;

        case (r_state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_opf_d   = cmd_opf_i;
                    w_delay_d = cmd_delay_i;
                    w_cnt_d   = w_cnt_clamped;
                    w_opv_d   = '0;
                    w_idx_d   = '0;
                    w_state_d = (w_cnt_clamped != '0) ? S_COLLECT : S_ISSUE;
                end
            end
            S_COLLECT: begin
                if (opnd_valid_i) begin
                    for (int k = 0; k < SRC_CNT; k++) begin
                        if (r_idx_q == c_CNT_W'(k)) begin
                            w_operand_d[k*DWIDTH +: DWIDTH] = opnd_data_i;
                            w_opv_d[k]                      = 1'b1;
                        end
                    end
                    w_idx_d = r_idx_q + c_IDX_ONE;
                    if (r_idx_q == r_cnt_q - c_IDX_ONE) begin
                        w_state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // done_i is not looked at here: the exec unit reloads its counter on start.
                w_wd_d    = '0;
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                w_wd_d = r_wd_q + 1'b1;
                if (done_i) begin
                    w_res_data_d = dout_i;
                    w_res_err_d  = 1'b0;
                    w_state_d    = S_RESP;
                end else if (r_wd_q == c_WD_LAST) begin
                    w_res_data_d = dout_i;
                    w_res_err_d  = 1'b1;
                    w_state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready_i) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_opf_q      <= '0;
            r_delay_q    <= '0;
            r_cnt_q      <= '0;
            r_idx_q      <= '0;
            r_operand_q  <= '0;
            r_opv_q      <= '0;
            r_wd_q       <= '0;
            r_res_data_q <= '0;
            r_res_err_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_opf_q      <= w_opf_d;
            r_delay_q    <= w_delay_d;
            r_cnt_q      <= w_cnt_d;
            r_idx_q      <= w_idx_d;
            r_operand_q  <= w_operand_d;
            r_opv_q      <= w_opv_d;
            r_wd_q       <= w_wd_d;
            r_res_data_q <= w_res_data_d;
            r_res_err_q  <= w_res_err_d;
        end
    end

    assign cmd_ready_o     = (r_state_q == S_IDLE);
    assign opnd_ready_o    = (r_state_q == S_COLLECT);
    assign start_o         = (r_state_q == S_ISSUE);
    assign res_valid_o     = (r_state_q == S_RESP);
    assign busy_o          = (r_state_q != S_IDLE);
    assign op_func_o       = r_opf_q;
    assign delay_o         = r_delay_q;
    assign operand_o       = r_operand_q;
    assign operand_valid_o = r_opv_q;
    assign res_data_o      = r_res_data_q;
    assign res_err_o       = r_res_err_q;

endmodule
`default_nettype wire
